// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and one-at-a-time instruction fetch over req/ack, with misaligned-target fault.
// Define FETCH_TIMEOUT_EN to fault when memory fails to ack within TIMEOUT_CYCLES.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        insn_valid,
    input  logic [31:0] nextpc,
    input  logic        commit,
    output logic [31:0] retired,
    output logic        fault,
    output logic [31:0] fault_pc
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
    state_t state, state_nx;

    logic take_ack, take_commit, bad_target, timeout;

    assign take_ack    = state == REQ && imem_ack;
    assign take_commit = state == HOLD && commit;
    assign bad_target  = nextpc[1:0] != 2'b00;

`ifdef FETCH_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WCW-1:0] wait_cnt;
    always_ff @(posedge clk) begin
        if (reset || state != REQ)
            wait_cnt <= '0;
        else if (!imem_ack)
            wait_cnt <= wait_cnt + 1'b1;
    end
    // the cycle that would bring the count to TIMEOUT_CYCLES trips the fault, unless ack arrives with it
    assign timeout = state == REQ && !imem_ack && int'(wait_cnt) == TIMEOUT_CYCLES - 1;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES > 0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = REQ;
            REQ:     state_nx = take_ack ? HOLD : (timeout ? FAULT : REQ);
            HOLD:    state_nx = commit ? (bad_target ? FAULT : REQ) : HOLD;
            default: state_nx = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            insn     <= NOP;
            retired  <= '0;
            fault_pc <= '0;
        end else begin
            if (take_ack)
                insn <= imem_rdata;
            if (take_commit) begin
                retired <= retired + 32'd1;
                if (bad_target)
                    fault_pc <= nextpc;
                else
                    pc <= nextpc;
            end
            if (timeout)
                fault_pc <= pc;
        end
    end

    assign imem_req   = state == REQ;
    assign insn_valid = state == HOLD;
    assign fault      = state == FAULT;
    assign imem_addr  = pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit in the default build (no fetch timeout).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        insn_valid;
    logic [31:0] nextpc = '0;
    logic        commit = 1'b0;
    logic [31:0] retired;
    logic        fault;
    logic [31:0] fault_pc;

    int n_pass = 0;
    int n_total = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .insn(insn), .pc(pc), .insn_valid(insn_valid),
        .nextpc(nextpc), .commit(commit),
        .retired(retired), .fault(fault), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_insn", insn, 32'h13);
        check("rst_valid", 32'(insn_valid), 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);

        // ack during IDLE must be ignored; it is then held for a zero-wait fetch
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        check("req0_req", 32'(imem_req), 32'h1);
        check("req0_addr", imem_addr, 32'h0);
        check("req0_valid", 32'(insn_valid), 32'h0);
        check("idle_ack_ignored", insn, 32'h13);
        tick();
        imem_ack = 1'b0;
        check("hold0_insn", insn, 32'h0050_0093);
        check("hold0_pc", pc, 32'h0);
        check("hold0_valid", 32'(insn_valid), 32'h1);
        check("hold0_retired", retired, 32'h0);
        check("hold0_req", 32'(imem_req), 32'h0);
        tick();
        check("hold_stay_valid", 32'(insn_valid), 32'h1);

        commit = 1'b1; nextpc = 32'h8;
        tick();
        check("c1_req", 32'(imem_req), 32'h1);
        check("c1_retired", retired, 32'h1);
        check("c1_valid", 32'(insn_valid), 32'h0);
        // commit pulse during REQ must not move pc or count
        nextpc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            check("req8_addr", imem_addr, 32'h8);
            tick();
            commit = 1'b0;
        end
        check("req8_addr4", imem_addr, 32'h8);
        check("req8_req4", 32'(imem_req), 32'h1);
        check("req8_retired", retired, 32'h1);
        imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
        tick();
        imem_ack = 1'b0;
        check("hold8_insn", insn, 32'h00A0_0113);
        check("hold8_valid", 32'(insn_valid), 32'h1);
        check("hold8_pc", pc, 32'h8);
        check("hold8_retired", retired, 32'h1);

        commit = 1'b1; nextpc = 32'hA;
        tick();
        check("flt_fault", 32'(fault), 32'h1);
        check("flt_fault_pc", fault_pc, 32'hA);
        check("flt_valid", 32'(insn_valid), 32'h0);
        check("flt_req", 32'(imem_req), 32'h0);
        check("flt_retired", retired, 32'h2);
        check("flt_pc", pc, 32'h8);
        imem_ack = 1'b1; nextpc = 32'h40;
        repeat (5) tick();
        check("flt_sticky", 32'(fault), 32'h1);
        check("flt_sticky_pc", fault_pc, 32'hA);
        check("flt_sticky_req", 32'(imem_req), 32'h0);
        check("flt_sticky_retired", retired, 32'h2);
        commit = 1'b0; imem_ack = 1'b0;

        // reach REQ at 0x20, then reset while an ack arrives
        reset = 1'b1;
        tick();
        check("rst2_fault", 32'(fault), 32'h0);
        check("rst2_retired", retired, 32'h0);
        reset = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0; commit = 1'b1; nextpc = 32'h20;
        tick();
        commit = 1'b0;
        check("req20_addr", imem_addr, 32'h20);
        check("req20_req", 32'(imem_req), 32'h1);
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("rst3_pc", pc, 32'h0);
        check("rst3_valid", 32'(insn_valid), 32'h0);
        check("rst3_insn", insn, 32'h13);
        check("rst3_req", 32'(imem_req), 32'h0);
        reset = 1'b0; imem_ack = 1'b0;
        tick();
        check("rst3_after_insn", insn, 32'h13);
        check("rst3_after_req", 32'(imem_req), 32'h1);
        check("rst3_after_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
